// File: rtl/lc2k_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_pkg
// Description : Shared definitions for the LC2K multi-cycle controller.
//               Holds the opcode constants, controller state encoding, and
//               the alu_op / pc_src / wb_sel encodings, plus a helper that
//               maps any opcode value that is not a defined instruction
//               onto NOOP.
// Revision    : 1.0 - initial release
// ============================================================================
package lc2k_pkg;

  // Opcode field encodings (instruction bits [24:22])
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  // Controller states
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_JALR   = 3'd5;
  localparam state_t ST_HALTED = 3'd6;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_NOR = 2'd1;
  localparam logic [1:0] ALU_EQ  = 2'd2;

  // PC source select
  localparam logic [1:0] PC_SRC_INC  = 2'd0;
  localparam logic [1:0] PC_SRC_OFF  = 2'd1;
  localparam logic [1:0] PC_SRC_REGA = 2'd2;

  // Register write-back source select
  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // Any value that does not exactly match a defined instruction (including
  // X/Z in simulation) falls through to NOOP so the controller never stalls
  // on a corrupt instruction word.
  function automatic logic [2:0] sanitize_op(input logic [2:0] op);
    case (op)
      OP_ADD, OP_NOR, OP_LW, OP_SW, OP_BEQ, OP_JALR, OP_HALT: sanitize_op = op;
      default:                                                sanitize_op = OP_NOOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc2k_ctrl_outdec.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_ctrl_outdec
// Description : Combinational control-output decoder for the LC2K
//               multi-cycle controller. Maps current state and latched
//               opcode (plus alu_eq / mem_ready) onto datapath controls.
// Ports       : state, op_q, alu_eq, mem_ready    -> decode inputs
//               mem_req, mem_we, mem_addr_sel      -> memory port controls
//               ir_write, pc_write, pc_src         -> IR / PC controls
//               alu_op, alu_src_b                  -> ALU controls
//               reg_write, reg_dst, wb_sel         -> register file controls
//               halted                             -> halt indication
// Revision    : 1.0 - initial release
// ============================================================================
module lc2k_ctrl_outdec
  import lc2k_pkg::*;
(
  input  logic [2:0] state,
  input  logic [2:0] op_q,
  input  logic       alu_eq,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] wb_sel,
  output logic       halted
);

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_INC;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = WB_MEM;
    halted       = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b0;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_INC;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_ADD;
          end
          OP_NOR: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_NOR;
          end
          OP_BEQ: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_EQ;
            if (alu_eq) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_OFF;
            end
          end
          default: begin
            // LW/SW: address = regA + offset
            alu_src_b = 1'b0;
            alu_op    = ALU_ADD;
          end
        endcase
      end

      ST_MEM: begin
        // ALU stays on regA + offset so the address is stable while waiting.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_SW);
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
      end

      ST_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_LW) begin
          reg_dst = 1'b0;
          wb_sel  = WB_MEM;
        end else begin
          reg_dst = 1'b1;
          wb_sel  = WB_ALU;
        end
      end

      ST_JALR: begin
        // PC already holds PC+1 from FETCH, so wb_sel=PC stores the link.
        reg_write = 1'b1;
        reg_dst   = 1'b0;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_REGA;
      end

      ST_HALTED: begin
        halted = 1'b1;
      end

      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lc2k_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc2k_multicycle_ctrl
// Description : Multi-cycle control FSM for the LC2K datapath. Sequences
//               fetch / decode / execute / memory / write-back over a shared
//               memory port and ALU, counts retired instructions
//               (saturating) and reports halt.
// Ports       : clk, reset            -> clock, synchronous active-high reset
//               opcode                -> IR[24:22], sampled in DECODE
//               alu_eq                -> ALU equality flag, used by BEQ
//               mem_ready             -> memory completes request this cycle
//               mem_* / ir_write / pc_* / alu_* / reg_* / wb_sel
//                                     -> datapath controls
//               halted                -> HALT retired, controller idle
//               instr_count           -> retired instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module lc2k_multicycle_ctrl
  import lc2k_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       opcode,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_op_q;
  logic [2:0]       w_dec_op;
  logic             w_retire;
  logic [CNT_W-1:0] r_count;

  logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_write, w_pc_write;
  logic [1:0] w_pc_src, w_alu_op, w_wb_sel;
  logic       w_alu_src_b, w_reg_write, w_reg_dst, w_halted;

  assign w_dec_op = sanitize_op(opcode);

  // Next-state and retire decode
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        case (w_dec_op)
          OP_JALR: w_next_state = ST_JALR;
          OP_HALT: begin
            w_next_state = ST_HALTED;
            w_retire     = 1'b1;
          end
          OP_NOOP: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
          end
          default: w_next_state = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (r_op_q)
          OP_ADD, OP_NOR: w_next_state = ST_WB;
          OP_LW, OP_SW:   w_next_state = ST_MEM;
          default: begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (r_op_q == OP_SW) begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
          end else begin
            w_next_state = ST_WB;
          end
        end
      end
      ST_WB, ST_JALR: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_op_q  <= OP_NOOP;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) r_op_q <= w_dec_op;
      if (w_retire && (r_count != C_CNT_MAX)) r_count <= r_count + 1'b1;
    end
  end

  lc2k_ctrl_outdec u_outdec (
    .state        (r_state),
    .op_q         (r_op_q),
    .alu_eq       (alu_eq),
    .mem_ready    (mem_ready),
    .mem_req      (w_mem_req),
    .mem_we       (w_mem_we),
    .mem_addr_sel (w_mem_addr_sel),
    .ir_write     (w_ir_write),
    .pc_write     (w_pc_write),
    .pc_src       (w_pc_src),
    .alu_op       (w_alu_op),
    .alu_src_b    (w_alu_src_b),
    .reg_write    (w_reg_write),
    .reg_dst      (w_reg_dst),
    .wb_sel       (w_wb_sel),
    .halted       (w_halted)
  );

  // Reset masks every output combinationally so a pending store or fetch
  // is withdrawn in the very cycle reset is asserted.
  assign mem_req      = w_mem_req      & ~reset;
  assign mem_we       = w_mem_we       & ~reset;
  assign mem_addr_sel = w_mem_addr_sel & ~reset;
  assign ir_write     = w_ir_write     & ~reset;
  assign pc_write     = w_pc_write     & ~reset;
  assign pc_src       = reset ? 2'd0 : w_pc_src;
  assign alu_op       = reset ? 2'd0 : w_alu_op;
  assign alu_src_b    = w_alu_src_b    & ~reset;
  assign reg_write    = w_reg_write    & ~reset;
  assign reg_dst      = w_reg_dst      & ~reset;
  assign wb_sel       = reset ? 2'd0 : w_wb_sel;
  assign halted       = w_halted       & ~reset;
  assign instr_count  = reset ? '0 : r_count;

endmodule
`default_nettype wire

// File: tb/tb_lc2k_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc2k_multicycle_ctrl
// Description : Scoreboard bench for lc2k_multicycle_ctrl. Each stimulus
//               cycle pushes the hand-derived expected outputs; a monitor
//               pops and compares them against the DUT in the same cycle.
//               A second instance with a 2-bit counter checks saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc2k_multicycle_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [1:0]  alu_op;
    logic        alu_src_b;
    logic        reg_write;
    logic        reg_dst;
    logic [1:0]  wb_sel;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  // Expected-output kinds per cycle
  localparam int K_ZERO   = 0;
  localparam int K_F_RDY  = 1;
  localparam int K_F_WAIT = 2;
  localparam int K_DEC    = 3;
  localparam int K_EX_ADD = 4;
  localparam int K_EX_NOR = 5;
  localparam int K_EX_MEM = 6;
  localparam int K_BEQ_T  = 7;
  localparam int K_BEQ_F  = 8;
  localparam int K_MEM_RD = 9;
  localparam int K_MEM_WR = 10;
  localparam int K_WB_ALU = 11;
  localparam int K_WB_LW  = 12;
  localparam int K_JALR   = 13;
  localparam int K_HALT   = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  opcode = 3'd7;
  logic        alu_eq = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src_b, reg_write, reg_dst, halted;
  logic [31:0] instr_count;

  logic        s_mem_req, s_mem_we, s_mem_addr_sel, s_ir_write, s_pc_write;
  logic [1:0]  s_pc_src, s_alu_op, s_wb_sel;
  logic        s_alu_src_b, s_reg_write, s_reg_dst, s_halted;
  logic [1:0]  s_instr_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lc2k_multicycle_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .halted(halted), .instr_count(instr_count)
  );

  lc2k_multicycle_ctrl #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_eq(alu_eq),
    .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we),
    .mem_addr_sel(s_mem_addr_sel), .ir_write(s_ir_write), .pc_write(s_pc_write),
    .pc_src(s_pc_src), .alu_op(s_alu_op), .alu_src_b(s_alu_src_b),
    .reg_write(s_reg_write), .reg_dst(s_reg_dst), .wb_sel(s_wb_sel),
    .halted(s_halted), .instr_count(s_instr_count)
  );

  function automatic exp_t mk(input int k, input logic [31:0] cnt);
    exp_t e;
    e = '0;
    e.count = cnt;
    case (k)
      K_F_RDY:  begin e.mem_req = 1; e.ir_write = 1; e.pc_write = 1; end
      K_F_WAIT: e.mem_req = 1;
      K_EX_ADD: e.alu_src_b = 1;
      K_EX_NOR: begin e.alu_src_b = 1; e.alu_op = 2'd1; end
      K_BEQ_T:  begin e.alu_src_b = 1; e.alu_op = 2'd2; e.pc_write = 1; e.pc_src = 2'd1; end
      K_BEQ_F:  begin e.alu_src_b = 1; e.alu_op = 2'd2; end
      K_MEM_RD: begin e.mem_req = 1; e.mem_addr_sel = 1; end
      K_MEM_WR: begin e.mem_req = 1; e.mem_addr_sel = 1; e.mem_we = 1; end
      K_WB_ALU: begin e.reg_write = 1; e.reg_dst = 1; e.wb_sel = 2'd1; end
      K_WB_LW:  e.reg_write = 1;
      K_JALR:   begin e.reg_write = 1; e.wb_sel = 2'd2; e.pc_write = 1; e.pc_src = 2'd2; end
      K_HALT:   e.halted = 1;
      default:  ;
    endcase
    return e;
  endfunction

  // One cycle of stimulus: drive inputs after the falling edge and push the
  // outputs expected for the rest of this cycle.
  task automatic cyc(input int k, input int cnt, input logic [2:0] op,
                     input logic ae, input logic mr, input logic rs);
    @(negedge clk);
    reset     = rs;
    opcode    = op;
    alu_eq    = ae;
    mem_ready = mr;
    exp_q.push_back(mk(k, cnt));
  endtask

  // Monitor: compare whatever the DUT presents against the queued entry.
  initial begin
    exp_t e;
    exp_t a;
    logic [1:0] sat_exp;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
             alu_op, alu_src_b, reg_write, reg_dst, wb_sel, halted, instr_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ctrl_outputs t=%0t actual=%h required=%h", $time, a, e);
        end
        sat_exp = (e.count > 32'd3) ? 2'd3 : e.count[1:0];
        checks++;
        if (s_instr_count !== sat_exp) begin
          errors++;
          $display("FAIL sat_count t=%0t actual=%0d required=%0d", $time, s_instr_count, sat_exp);
        end
      end
    end
  end

  initial begin
    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) cyc(K_ZERO, 0, 3'd7, 0, 1, 1);
    // ADD
    cyc(K_F_RDY, 0, 3'd0, 0, 1, 0);
    cyc(K_DEC,   0, 3'd0, 0, 1, 0);
    cyc(K_EX_ADD,0, 3'd0, 0, 1, 0);
    cyc(K_WB_ALU,0, 3'd0, 0, 1, 0);
    // NOR
    cyc(K_F_RDY, 1, 3'd1, 0, 1, 0);
    cyc(K_DEC,   1, 3'd1, 0, 1, 0);
    cyc(K_EX_NOR,1, 3'd1, 0, 1, 0);
    cyc(K_WB_ALU,1, 3'd1, 0, 1, 0);
    // LW with two wait cycles in MEM
    cyc(K_F_RDY, 2, 3'd2, 0, 1, 0);
    cyc(K_DEC,   2, 3'd2, 0, 1, 0);
    cyc(K_EX_MEM,2, 3'd2, 0, 1, 0);
    cyc(K_MEM_RD,2, 3'd2, 0, 0, 0);
    cyc(K_MEM_RD,2, 3'd2, 0, 0, 0);
    cyc(K_MEM_RD,2, 3'd2, 0, 1, 0);
    cyc(K_WB_LW, 2, 3'd2, 0, 1, 0);
    // BEQ taken, then not taken
    cyc(K_F_RDY, 3, 3'd4, 0, 1, 0);
    cyc(K_DEC,   3, 3'd4, 0, 1, 0);
    cyc(K_BEQ_T, 3, 3'd4, 1, 1, 0);
    cyc(K_F_RDY, 4, 3'd4, 0, 1, 0);
    cyc(K_DEC,   4, 3'd4, 0, 1, 0);
    cyc(K_BEQ_F, 4, 3'd4, 0, 1, 0);
    // JALR
    cyc(K_F_RDY, 5, 3'd5, 0, 1, 0);
    cyc(K_DEC,   5, 3'd5, 0, 1, 0);
    cyc(K_JALR,  5, 3'd5, 0, 1, 0);
    // NOOP with one fetch wait cycle
    cyc(K_F_WAIT,6, 3'd7, 0, 0, 0);
    cyc(K_F_RDY, 6, 3'd7, 0, 1, 0);
    cyc(K_DEC,   6, 3'd7, 0, 1, 0);
    // SW with one wait cycle in MEM
    cyc(K_F_RDY, 7, 3'd3, 0, 1, 0);
    cyc(K_DEC,   7, 3'd3, 0, 1, 0);
    cyc(K_EX_MEM,7, 3'd3, 0, 1, 0);
    cyc(K_MEM_WR,7, 3'd3, 0, 0, 0);
    cyc(K_MEM_WR,7, 3'd3, 0, 1, 0);
    // HALT, then count frozen while mem_ready toggles
    cyc(K_F_RDY, 8, 3'd6, 0, 1, 0);
    cyc(K_DEC,   8, 3'd6, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(K_HALT, 9, 3'd0, i[0], i[0], 0);
    // Reset out of HALTED, then reset while SW waits in MEM
    cyc(K_ZERO,  0, 3'd3, 0, 0, 1);
    cyc(K_F_RDY, 0, 3'd3, 0, 1, 0);
    cyc(K_DEC,   0, 3'd3, 0, 1, 0);
    cyc(K_EX_MEM,0, 3'd3, 0, 1, 0);
    cyc(K_MEM_WR,0, 3'd3, 0, 0, 0);
    cyc(K_ZERO,  0, 3'd3, 0, 0, 1);
    cyc(K_ZERO,  0, 3'd3, 0, 1, 1);
    // Restart in FETCH with a NOOP
    cyc(K_F_WAIT,0, 3'd7, 0, 0, 0);
    cyc(K_F_RDY, 0, 3'd7, 0, 1, 0);
    cyc(K_DEC,   0, 3'd7, 0, 1, 0);
    cyc(K_F_WAIT,1, 3'd7, 0, 0, 0);

    // Give the monitor a bounded window to drain the queue.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lc2k_multicycle_ctrl.md
# lc2k_multicycle_ctrl

Multi-cycle control FSM for the LC2K datapath. It replaces per-instruction static control decode with a sequenced controller that shares a single memory port between instruction fetch and data access, and a single ALU between compare and address/arith work. It sits between the instruction register/ALU flags and the datapath muxes and enables. It also counts retired instructions and reports halt.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  3  bits [24:22] of instruction register; sampled only in DECODE
- alu_eq  in  1  ALU equality result (regA==regB); sampled only in EXEC of BEQ
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read (valid with mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register from memory data
- pc_write  out  1  load PC
- pc_src  out  2  0 = PC+1, 1 = PC+offset, 2 = regA
- alu_op  out  2  00 add, 01 nor, 10 equal
- alu_src_b  out  1  1 = regB, 0 = sign-extended offset
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = destReg field, 0 = regB field
- wb_sel  out  2  0 = memory data, 1 = ALU result, 2 = PC
- halted  out  1  HALT retired; controller idle
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- Opcodes: ADD 0, NOR 1, LW 2, SW 3, BEQ 4, JALR 5, HALT 6, NOOP 7.
- States: FETCH, DECODE, EXEC, MEM, WB, JALR, HALTED. Outputs default 0 unless listed. Outputs are decoded from state and op_q; the exception is DECODE, which uses opcode.
- FETCH: mem_req=1, mem_addr_sel=0.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise hold.
- DECODE: latch opcode into op_q. Next state by opcode:
  - 0–4 go to EXEC.
  - 5 goes to JALR.
  - 6 goes to HALTED and retires.
  - 7 goes to FETCH and retires.
- EXEC:
  - ADD/NOR: alu_src_b=1, alu_op=00/01, then WB.
  - LW/SW: alu_src_b=0, alu_op=00, then MEM.
  - BEQ: alu_src_b=1, alu_op=10. If alu_eq: pc_write=1, pc_src=1. Then FETCH and retire.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(op_q==SW), ALU held at add/offset.
  - When mem_ready: LW goes to WB; SW goes to FETCH and retires.
  - Otherwise hold with outputs stable.
- WB: reg_write=1, then FETCH and retire.
  - ADD/NOR: reg_dst=1, wb_sel=1.
  - LW: reg_dst=0, wb_sel=0.
- JALR: reg_write=1, reg_dst=0, wb_sel=2 (PC already incremented), pc_write=1, pc_src=2, then FETCH and retire. When regA==regB, the register-file read-before-write ordering gives jump-to-old-regA.
- HALTED: halted=1, all other outputs 0, mem_ready ignored. Exited only by reset.
- instr_count: +1 on each retire event. Holds at 2^CNT_W−1.

## Timing
- Reset (sampled high at edge):
  - state ← FETCH, op_q ← NOOP, instr_count ← 0.
  - While reset is high, every output is forced 0, including instr_count.
  - First FETCH cycle is the first edge after reset falls.
- Cycles per instruction with zero-wait memory (mem_ready high in the first request cycle):
  - NOOP 2, HALT 2 (halted high in cycle 3), BEQ 3, JALR 3, ADD/NOR 4, SW 4, LW 5.
  - Each low mem_ready cycle in FETCH or MEM adds one cycle.
- mem_req stays high and address/we stay stable from request start until the mem_ready cycle inclusive. Next cycle mem_req drops unless a new FETCH follows.
- The count update is registered: visible the cycle after the retiring cycle.
- Reset mid-MEM (SW pending): no write is committed beyond that cycle; mem_req is 0 during reset.
- Unknown/X opcode in DECODE is treated as NOOP.

## Structure
- Shared package lc2k_pkg holds:
  - opcode constants
  - state enum
  - alu_op, pc_src and wb_sel encodings
- One sub-module: lc2k_ctrl_outdec, the combinational state/op → control-output decoder.
- The FSM registers, op_q and counter stay in the top module.

## Test plan
- Reset held 3 cycles, then ADD with mem_ready always 1 → ir_write at cycle 1, reg_write=1/reg_dst=1/wb_sel=1 at cycle 4, instr_count=1 at cycle 5.
- LW with mem_ready low 2 cycles in MEM → mem_req=1, mem_addr_sel=1, mem_we=0 held 3 cycles; WB at cycle 7 with wb_sel=0, reg_dst=0.
- BEQ with alu_eq=1, then BEQ with alu_eq=0 → pc_write=1/pc_src=1 only in the first EXEC; both retire in 3 cycles; count=2.
- JALR → cycle 3 asserts reg_write, wb_sel=2, pc_write, pc_src=2 together.
- SW, then HALT → mem_we=1 only in MEM; halted=1 from cycle 7; instr_count=2 and frozen while mem_ready toggles.
- Reset asserted in the middle of a waiting SW MEM → mem_req drops same cycle; restart in FETCH, instr_count=0.
